// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store front end for a word-addressed data memory.
// Sub-word stores use read-modify-write; define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
`default_nettype none

module load_store_unit #(
   parameter int MEM_BYTES = 4096,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [ADDR_W-1:0] addr_eff;
   logic [ADDR_W:0]   last_byte;
   logic [ADDR_W:0]   span;
   logic              misaligned;
   logic              req_bad;
   logic [31:0]       lane_data;
   logic [31:0]       load_ext;
   logic [31:0]       merged;

   // Address actually used for the access and for the range check.
   always_comb begin
      addr_eff   = req_addr;
      misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
      if (req_size == 2'b01) addr_eff[0]   = 1'b0;
      if (req_size == 2'b10) addr_eff[1:0] = 2'b00;
`endif
      case (req_size)
         2'b00:   span = '0;
         2'b01:   span = (ADDR_W+1)'(1);
         default: span = (ADDR_W+1)'(3);
      endcase
      last_byte = {1'b0, addr_eff} + span;
      req_bad   = (req_size == 2'b11) || misaligned ||
                  (last_byte >= (ADDR_W+1)'(MEM_BYTES));
   end

   // Load lane select and extension.
   always_comb begin
      lane_data = mem_rdata >> {addr_q[1:0], 3'b000};
      case (size_q)
         2'b00:   load_ext = {{24{~uns_q & lane_data[7]}}, lane_data[7:0]};
         2'b01:   load_ext = {{16{~uns_q & lane_data[15]}}, lane_data[15:0]};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      merged = mem_rdata;
      case (size_q)
         2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
         2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = addr_eff;
               wdata_d = req_wdata;
               rdata_d = '0;
               if (req_bad) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!we_q) rdata_d = load_ext;
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // rst_n gating keeps a store in flight from landing while reset is asserted.
   assign mem_we    = (state_q == ACCESS) && we_q && rst_n;
   assign mem_addr  = (state_q == ACCESS) ? 32'({addr_q[ADDR_W-1:2], 2'b00}) : 32'd0;
   assign mem_wdata = ((state_q == ACCESS) && we_q) ? merged : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven scoreboard bench with a behavioural word memory.
`default_nettype none

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_BYTES(4096), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   logic [31:0] mem [0:1023];
   int          we_cnt = 0;
   logic [31:0] last_wdata = '0;

   assign mem_rdata = mem[mem_addr[11:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[11:2]] <= mem_wdata;
         we_cnt     <= we_cnt + 1;
         last_wdata <= mem_wdata;
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_nwe;
      logic [31:0] exp_wdata;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exp_err, input logic [31:0] exp_rdata,
                               input int exp_nwe, input logic [31:0] exp_wdata);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_err = exp_err; v.exp_rdata = exp_rdata;
      v.exp_nwe = exp_nwe; v.exp_wdata = exp_wdata;
      return v;
   endfunction

   task automatic do_txn(input vec_t v, input int hold);
      int   cyc;
      int   we0;
      exp_t e;
      logic [31:0] held;
      @(negedge clk);
      check("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid    = 1'b1;
      req_we       = v.we;
      req_size     = v.size;
      req_unsigned = v.uns;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      @(posedge clk);
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      sb.push_back(e);
      we0 = we_cnt;
      #1 req_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!resp_valid && cyc < 8);
      check("resp_latency", 32'(cyc), v.exp_err ? 32'd1 : 32'd2);
      e = sb.pop_front();
      check("resp_rdata", resp_rdata, e.rdata);
      check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
      held = resp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", {31'd0, resp_valid}, 32'd1);
         check("hold_rdata", resp_rdata, held);
         check("hold_req_ready", {31'd0, req_ready}, 32'd0);
         check("hold_mem_we", {31'd0, mem_we}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      check("post_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("post_resp_rdata", resp_rdata, 32'd0);
      check("post_resp_err", {31'd0, resp_err}, 32'd0);
      check("post_req_ready", {31'd0, req_ready}, 32'd1);
      check("mem_we_cycles", 32'(we_cnt - we0), 32'(v.exp_nwe));
      if (v.exp_nwe != 0) check("mem_wdata", last_wdata, v.exp_wdata);
   endtask

   task automatic check_reset_outputs();
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_err", {31'd0, resp_err}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout expected completion)");
      $fatal(1, "watchdog");
   end

   initial begin
      int we0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[4] = 32'h8877_6655;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

      // loads on the 0x8877_6655 word
      tbl.push_back(mk(0, 2'b00, 0, 32'h13, 0, 0, 32'hFFFF_FF88, 0, 0));
      tbl.push_back(mk(0, 2'b00, 1, 32'h13, 0, 0, 32'h0000_0088, 0, 0));
      tbl.push_back(mk(0, 2'b00, 0, 32'h10, 0, 0, 32'h0000_0055, 0, 0));
      tbl.push_back(mk(0, 2'b01, 1, 32'h12, 0, 0, 32'h0000_8877, 0, 0));
      tbl.push_back(mk(0, 2'b01, 0, 32'h12, 0, 0, 32'hFFFF_8877, 0, 0));
      tbl.push_back(mk(0, 2'b10, 0, 32'h10, 0, 0, 32'h8877_6655, 0, 0));
      // RMW byte store then read back
      tbl.push_back(mk(1, 2'b00, 0, 32'h11, 32'h1234_56AB, 0, 0, 1, 32'h8877_AB55));
      tbl.push_back(mk(0, 2'b10, 0, 32'h10, 0, 0, 32'h8877_AB55, 0, 0));
      // top-of-memory boundary and out-of-range / illegal size
      tbl.push_back(mk(1, 2'b01, 0, 32'hFFE, 32'hFFFF_1234, 0, 0, 1, 32'h1234_0000));
      tbl.push_back(mk(0, 2'b01, 1, 32'hFFE, 0, 0, 32'h0000_1234, 0, 0));
      tbl.push_back(mk(0, 2'b00, 0, 32'h1000, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 2'b00, 0, 32'h1000, 32'hFF, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2'b11, 0, 32'h10, 0, 1, 0, 0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
      tbl.push_back(mk(1, 2'b10, 0, 32'hFFE, 32'hCAFE_F00D, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2'b10, 0, 32'hFFC, 0, 0, 32'h1234_0000, 0, 0));
      tbl.push_back(mk(0, 2'b01, 0, 32'h11, 0, 1, 0, 0, 0));
`else
      tbl.push_back(mk(1, 2'b10, 0, 32'hFFE, 32'hCAFE_F00D, 0, 0, 1, 32'hCAFE_F00D));
      tbl.push_back(mk(0, 2'b10, 0, 32'hFFC, 0, 0, 32'hCAFE_F00D, 0, 0));
      tbl.push_back(mk(0, 2'b01, 0, 32'h11, 0, 0, 32'hFFFF_AB55, 0, 0));
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;

      foreach (tbl[i]) do_txn(tbl[i], 0);

      // backpressure: response held for 5 cycles
      do_txn(mk(0, 2'b10, 0, 32'h10, 0, 0, 32'h8877_AB55, 0, 0), 5);

      // reset asserted during the ACCESS cycle of a store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      we0 = we_cnt;
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1 check("rst_access_mem_we", {31'd0, mem_we}, 32'd0);
      @(posedge clk);
      #1;
      check_reset_outputs();
      check("rst_access_no_write", 32'(we_cnt - we0), 32'd0);
      check("rst_access_mem", mem[8], 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_txn(mk(0, 2'b10, 0, 32'h20, 0, 0, 32'h0000_0000, 0, 0), 0);
      do_txn(mk(1, 2'b00, 0, 32'h22, 32'h0000_005A, 0, 0, 1, 32'h005A_0000), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory, between the CPU execute stage and that memory.
- Converts CPU byte, halfword and word loads/stores into 32-bit word accesses.
- Sub-word stores are done as read-modify-write (RMW) over the memory's asynchronous read port.
- Performs load sign/zero extension and flags misaligned or out-of-range accesses.
- Uses a valid/ready request and response handshake toward the CPU.

Parameters:
- MEM_BYTES, 4096, size of the data memory in bytes; addresses >= MEM_BYTES are out of range.
- ADDR_W, 32, CPU address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  CPU request valid.
- req_ready  output  1  LSU can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data; low bits used for sub-word stores.
- resp_valid  output  1  response valid.
- resp_ready  input  1  CPU accepts response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range or illegal size.
- mem_we  output  1  memory write enable.
- mem_addr  output  32  word-aligned byte address to memory (bits[1:0] = 00).
- mem_wdata  output  32  merged write word.
- mem_rdata  input  32  asynchronous read data for mem_addr.

Behaviour:
- The FSM has three states: IDLE, ACCESS and RESP. Reset (rst_n low at a clk edge) forces IDLE.
- Reset values:
  - req_ready = 1.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - All latched request registers = 0.
- mem_we is gated combinationally with rst_n, so no write is ever committed while rst_n is low.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we/size/unsigned/addr/wdata.
  - If the error check fails, go to RESP with resp_err = 1. No memory access occurs and mem_we is never asserted.
  - Otherwise go to ACCESS.
- Error check (resp_err = 1 if any of these hold):
  - size 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 00;
  - addr + bytes - 1 >= MEM_BYTES.
- ACCESS (exactly one cycle):
  - req_ready = 0; mem_addr = {latched addr[ADDR_W-1:2], 2'b00}.
  - Load: select the lane by addr[1:0] (byte) or addr[1] (half), extend per req_unsigned, and register into resp_rdata.
  - Store: mem_we = 1. mem_wdata = mem_rdata with the addressed lanes replaced by wdata[7:0], wdata[15:0] or all 32 bits.
  - The write takes effect at the end of the ACCESS cycle. Next state is RESP.
- RESP:
  - resp_valid = 1; resp_rdata/resp_err are held stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE. resp_valid drops and resp_err/resp_rdata clear to 0 in the same edge.
  - req_ready = 0 while in RESP; no request overlap.
- Latency:
  - Accept at edge N; ACCESS in cycle N+1; resp_valid from cycle N+2.
  - Best-case throughput is one transaction per 3 cycles.
  - An error response is visible from cycle N+1.
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k].
- Reset mid-operation:
  - In ACCESS, the pending store is dropped (mem_we low).
  - In RESP, the response is discarded.
  - The FSM returns to IDLE on the next edge.
- Backpressure: resp_ready held low keeps the FSM in RESP indefinitely. Outputs stay stable and no memory activity occurs.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned half/word accesses produce a resp_err response, as described above.
- Undefined:
  - The misalignment checks are removed. The address is aligned down (half: addr[0] = 0; word: addr[1:0] = 00) and the access proceeds normally.
  - Out-of-range and size-11 checks remain in both builds.

Test Plan:
- Memory word 0x10 = 0x8877_6655; load byte signed at addr 0x13 -> resp_rdata 0xFFFF_FF88, resp_err 0, resp_valid in cycle N+2.
- Same word; load half unsigned at 0x12 -> 0x0000_8877; load word at 0x10 -> 0x8877_6655.
- Store byte 0xAB at 0x11 over 0x8877_6655 -> exactly one mem_we cycle, mem_wdata 0x8877_AB55; a follow-up load word returns 0x8877_AB55.
- Store half at 0x0FFE (MEM_BYTES = 4096) -> accepted. Store word at 0x0FFE with macro defined -> resp_err 1, mem_we never high. Load byte at 0x1000 -> resp_err 1.
- Hold resp_ready = 0 for 5 cycles after a load -> resp_valid and resp_rdata held stable, req_ready 0. Release -> IDLE next cycle, req_ready 1.
- Assert rst_n = 0 during the ACCESS cycle of a store of 0xDEAD_BEEF to 0x20 -> mem_we stays 0, memory unchanged, all outputs at reset values. After release, a new request is accepted.
